reglk_access_gate: RTL
======================

Name: reglk_access_gate

Overview:
- Bus-side access controller placed directly upstream of the word-addressed data memory (negedge write, combinational read, 3-bit mem_width codes).
- Owns the register-lock bank. Each lock bit protects one 32-bit memory word.
- Accepts CPU requests over a valid/ready handshake, checks width, alignment and lock state, forwards permitted accesses as one-cycle memory strobes, and returns a response with an error flag.
- Lock state is cleared only by the global reset. There is no block-local reset, JTAG path or other unlock path.

Parameters:
- NUM_LOCK_WORDS, 6, number of 32-bit lock words. Together they cover memory words 0..NUM_LOCK_WORDS*32-1.
- LOCK_BASE, 32'h0000_0400, byte base of the 8-word lock window. Must be 32-byte aligned and lie outside the memory range.
- VIOL_W, 16, width of the saturating violation counter.

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  gate can accept a request
- req_write  in  1  1=write, 0=read
- req_width  in  3  mem_width code (000 SB, 001 SH, 010 W, 100 UB, 101 UH)
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- resp_valid  out  1  response valid
- resp_ready  in  1  response accepted
- resp_err  out  1  request rejected
- resp_rdata  out  32  read data (0 on error or write)
- mem_write_enable  out  1  write strobe to memory
- mem_width  out  3  width to memory
- mem_addr  out  32  address to memory
- mem_write_data  out  32  data to memory
- mem_read_data  in  32  combinational read data from memory
- lock_final  out  1  lock bank is frozen
- viol_count  out  VIOL_W  blocked-write count

Behaviour:
- Reset (async, immediate): state=IDLE; every reglk word=32'hFFFF_FFFF (all locked); lock_final=0; viol_count=0; resp_valid=0; resp_err=0; resp_rdata=0; all mem_* outputs=0.
- req_ready=1 only in IDLE, so it reads 1 immediately after reset.
- FSM states IDLE, CHECK, ISSUE, RESP.
  - IDLE: on req_valid&req_ready, capture write, width, addr and wdata, then go to CHECK.
  - CHECK: evaluate the request.
    - err if width is 011/110/111.
    - err if a halfword access has addr[0]=1.
    - err if a word access has addr[1:0]!=0.
    - Lock-window hit (addr[31:5]==LOCK_BASE[31:5]): handled locally, memory untouched, go to RESP.
    - Memory access: word index w=addr[31:2]. The word is locked if w<NUM_LOCK_WORDS*32 and reglk[w/32][w%32]=1. A write to a locked word (any width) gives err=1 and viol_count+1, saturating at all-ones.
    - Any error goes to RESP. Otherwise go to ISSUE.
  - ISSUE: exactly one cycle. mem_addr, mem_width and mem_write_data are driven; mem_write_enable=req_write.
    - Memory samples the write on the negedge inside this cycle.
    - Read: resp_rdata is captured from mem_read_data at the closing posedge.
    - All mem_* outputs return to 0 after this cycle.
  - RESP: resp_valid=1; resp_err and resp_rdata are held stable until resp_ready. On resp_valid&resp_ready, go to IDLE.
- Latency with resp_ready tied 1 (accept at posedge N):
  - Memory access: resp_valid high in cycle N+3.
  - Error or lock-window access: resp_valid high in cycle N+2.
  - Back-to-back throughput: one request per 4 cycles.
- Lock window accesses must use width 010; any other width gives err. Word offsets:
  - 0..5: reglk[j]. Read always allowed. Write allowed only when lock_final=0; otherwise err and viol_count+1.
  - 6: LOCK_FINAL. Write with wdata[0]=1 sets lock_final, which stays sticky until rst. wdata[0]=0 is a no-op. Reads return {31'b0, lock_final}.
  - 7: status, read-only. Reads return viol_count zero-extended. A write gives err and no count.
- Reads of locked memory words are permitted. Locks gate writes only.
- Words at or above NUM_LOCK_WORDS*32 are always writable.
- rst during ISSUE drops mem_write_enable asynchronously. No partial write is issued after rst is released.
- Reset in mid-response discards the response.

Decomposition:
- Package reglk_pkg holds:
  - the width localparams SIGNED_B, SIGNED_H, SIGNED_W, USIGNED_B, USIGNED_H;
  - the state enum gate_state_t;
  - window offsets LK_OFF_FINAL=6 and LK_OFF_STATUS=7.
- Sub-module reglk_lock_bank holds the reglk registers, lock_final, the per-word lock lookup (word index in, locked out) and write-port arbitration.
- The FSM and the violation counter stay in reglk_access_gate.

Test Plan:
- After reset, write W 0x0000_0010 data 0xDEAD_BEEF → resp_err=1, mem_write_enable never pulses, viol_count=1. A read of the same address returns the memory contents with resp_err=0.
- Write lock window word 0 = 0x0000_0000, then write W 0x10 = 0xDEAD_BEEF → resp_err=0, mem_write_enable high for one cycle, resp_valid at N+3. A read-back returns 0xDEAD_BEEF.
- Write 0x1 to LOCK_FINAL (0x418), then write lock word 0 = 0xFFFF_FFFF → resp_err=1, lock word unchanged (still 0), viol_count increments. Assert rst → lock word reads 0xFFFF_FFFF and lock_final=0.
- Misaligned and illegal requests: SH at 0x21, W at 0x22, width 3'b111, and SB access to the lock window → each gives resp_err=1, no memory strobe, viol_count unchanged.
- Hold resp_ready=0 for 5 cycles during RESP → resp_valid, resp_err and resp_rdata stay stable and req_ready=0. Release → IDLE the next cycle.
- Assert rst while in ISSUE with a write pending → mem_write_enable falls immediately and the target word is unchanged. Separately, force viol_count to 0xFFFE and issue 3 blocked writes → viol_count saturates at 0xFFFF.

Source files
------------

// File: rtl/reglk_pkg.sv
// Shared definitions for the register-lock access gate: memory width codes,
// gate FSM states and lock-window word offsets.
package reglk_pkg;

    localparam logic [2:0] SIGNED_B  = 3'b000;
    localparam logic [2:0] SIGNED_H  = 3'b001;
    localparam logic [2:0] SIGNED_W  = 3'b010;
    localparam logic [2:0] USIGNED_B = 3'b100;
    localparam logic [2:0] USIGNED_H = 3'b101;

    localparam logic [2:0] LK_OFF_FINAL  = 3'd6;
    localparam logic [2:0] LK_OFF_STATUS = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ISSUE,
        RESP
    } gate_state_t;

    // True when the width code is legal and the address is naturally aligned for it.
    function automatic logic access_ok(input logic [2:0] width, input logic [1:0] addr_lo);
        case (width)
            SIGNED_B, USIGNED_B: access_ok = 1'b1;
            SIGNED_H, USIGNED_H: access_ok = ~addr_lo[0];
            SIGNED_W:            access_ok = (addr_lo == 2'b00);
            default:             access_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/reglk_lock_bank.sv
// Register-lock bank: one lock bit per memory word plus the sticky lock_final
// bit that freezes the bank until the next global reset.
module reglk_lock_bank
    import reglk_pkg::*;
#(
    parameter int NUM_LOCK_WORDS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] word_idx,
    output logic        word_locked,
    input  logic [2:0]  rd_off,
    output logic [31:0] rd_data,
    input  logic        wr_en,
    input  logic [2:0]  wr_off,
    input  logic [31:0] wr_data,
    output logic        wr_blocked,
    output logic        lock_final
);

    logic [31:0] reglk [NUM_LOCK_WORDS];

    // Words beyond the covered range have no lock bit and are never locked.
    always_comb begin
        word_locked = 1'b0;
        for (int i = 0; i < NUM_LOCK_WORDS; i++) begin
            if (word_idx[29:5] == 25'(i)) begin
                word_locked = reglk[i][word_idx[4:0]];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_LOCK_WORDS; i++) begin
            if (rd_off == 3'(i)) begin
                rd_data = reglk[i];
            end
        end
        if (rd_off == LK_OFF_FINAL) begin
            rd_data = {31'b0, lock_final};
        end
    end

    assign wr_blocked = lock_final && (int'(wr_off) < NUM_LOCK_WORDS);

    // Once lock_final is set the lock words ignore writes; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LOCK_WORDS; i++) begin
                reglk[i] <= '1;
            end
            lock_final <= 1'b0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_LOCK_WORDS; i++) begin
                if (wr_off == 3'(i) && !lock_final) begin
                    reglk[i] <= wr_data;
                end
            end
            if (wr_off == LK_OFF_FINAL && wr_data[0]) begin
                lock_final <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/reglk_access_gate.sv
// Bus-side access controller in front of the data memory: checks width,
// alignment and lock state, then issues one-cycle memory strobes.
module reglk_access_gate
    import reglk_pkg::*;
#(
    parameter int          NUM_LOCK_WORDS = 6,
    parameter logic [31:0] LOCK_BASE      = 32'h0000_0400,
    parameter int          VIOL_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_width,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_write_enable,
    output logic [2:0]        mem_width,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data,
    output logic              lock_final,
    output logic [VIOL_W-1:0] viol_count
);

    gate_state_t state, state_next;
    logic        write_q;
    logic [2:0]  width_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        fmt_ok, in_window, word_locked, bank_wr_blocked;
    logic        check_err, check_viol, bank_wr_en;
    logic [2:0]  win_off;
    logic [31:0] bank_rd_data, win_rdata;

    reglk_lock_bank #(.NUM_LOCK_WORDS(NUM_LOCK_WORDS)) u_bank (
        .clk         (clk),
        .rst         (rst),
        .word_idx    (addr_q[31:2]),
        .word_locked (word_locked),
        .rd_off      (win_off),
        .rd_data     (bank_rd_data),
        .wr_en       (bank_wr_en),
        .wr_off      (win_off),
        .wr_data     (wdata_q),
        .wr_blocked  (bank_wr_blocked),
        .lock_final  (lock_final)
    );

    assign win_off   = addr_q[4:2];
    assign in_window = (addr_q[31:5] == LOCK_BASE[31:5]);
    assign fmt_ok    = access_ok(width_q, addr_q[1:0]);

    // Format errors take precedence and never count as violations.
    always_comb begin
        check_err  = 1'b0;
        check_viol = 1'b0;
        bank_wr_en = 1'b0;
        win_rdata  = (win_off == LK_OFF_STATUS) ? 32'(viol_count) : bank_rd_data;
        if (!fmt_ok) begin
            check_err = 1'b1;
        end else if (in_window) begin
            if (width_q != SIGNED_W) begin
                check_err = 1'b1;
            end else if (write_q) begin
                if (win_off == LK_OFF_STATUS) begin
                    check_err = 1'b1;
                end else if (bank_wr_blocked) begin
                    check_err  = 1'b1;
                    check_viol = 1'b1;
                end else begin
                    bank_wr_en = (state == CHECK);
                end
            end
        end else if (write_q && word_locked) begin
            check_err  = 1'b1;
            check_viol = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = CHECK;
            CHECK:   state_next = (check_err || in_window) ? RESP : ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory strobes decode straight from state so reset drops them at once.
    always_comb begin
        req_ready        = (state == IDLE);
        resp_valid       = (state == RESP);
        mem_write_enable = 1'b0;
        mem_width        = 3'b000;
        mem_addr         = '0;
        mem_write_data   = '0;
        if (state == ISSUE) begin
            mem_write_enable = write_q;
            mem_width        = width_q;
            mem_addr         = addr_q;
            mem_write_data   = wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q    <= 1'b0;
            width_q    <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            viol_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        width_q <= req_width;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                    end
                end
                CHECK: begin
                    resp_err   <= check_err;
                    resp_rdata <= (in_window && !check_err && !write_q) ? win_rdata : '0;
                    if (check_viol && viol_count != '1) begin
                        viol_count <= viol_count + VIOL_W'(1);
                    end
                end
                ISSUE: begin
                    resp_rdata <= write_q ? '0 : mem_read_data;
                end
                default: ;
            endcase
        end
    end

endmodule
